// File: rtl/div_dispatch_if.sv
// Handshake bundle between the issue stage, the dispatcher, the serial divider and writeback.
// The slave modport is the dispatcher's view; master is the surrounding environment.
interface div_dispatch_if #(
    parameter int WIDTH         = 64,
    parameter int TRANS_ID_BITS = 3
) ();
    logic                     flush_i;
    logic                     fu_valid_i;
    logic                     fu_ready_o;
    logic [TRANS_ID_BITS-1:0] id_i;
    logic [WIDTH-1:0]         op_a_i;
    logic [WIDTH-1:0]         op_b_i;
    logic [1:0]               opcode_i;

    logic                     div_vld_o;
    logic                     div_rdy_i;
    logic [TRANS_ID_BITS-1:0] div_id_o;
    logic [WIDTH-1:0]         div_op_a_o;
    logic [WIDTH-1:0]         div_op_b_o;
    logic [1:0]               div_opcode_o;
    logic                     div_flush_o;

    logic                     div_out_vld_i;
    logic                     div_out_rdy_o;
    logic [TRANS_ID_BITS-1:0] div_id_i;
    logic [WIDTH-1:0]         div_res_i;

    logic                     wb_valid_o;
    logic                     wb_ready_i;
    logic [TRANS_ID_BITS-1:0] wb_id_o;
    logic [WIDTH-1:0]         wb_result_o;
    logic                     id_err_o;

    modport slave (
        input  flush_i, fu_valid_i, id_i, op_a_i, op_b_i, opcode_i,
        input  div_rdy_i, div_out_vld_i, div_id_i, div_res_i, wb_ready_i,
        output fu_ready_o, div_vld_o, div_id_o, div_op_a_o, div_op_b_o, div_opcode_o,
        output div_flush_o, div_out_rdy_o, wb_valid_o, wb_id_o, wb_result_o, id_err_o
    );

    modport master (
        output flush_i, fu_valid_i, id_i, op_a_i, op_b_i, opcode_i,
        output div_rdy_i, div_out_vld_i, div_id_i, div_res_i, wb_ready_i,
        input  fu_ready_o, div_vld_o, div_id_o, div_op_a_o, div_op_b_o, div_opcode_o,
        input  div_flush_o, div_out_rdy_o, wb_valid_o, wb_id_o, wb_result_o, id_err_o
    );
endinterface

// File: rtl/div_dispatch.sv
// Dispatcher in front of a single-outstanding serial divider: launches requests, short-circuits
// divide-by-zero, and funnels results through a 2-entry in-order writeback FIFO.
module div_dispatch #(
    parameter int WIDTH         = 64,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    div_dispatch_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic                     div_rdy_q;
    logic                     flush_q;
    logic [TRANS_ID_BITS-1:0] id_q, id_d;
    logic                     id_err_q, id_err_d;

    logic [TRANS_ID_BITS-1:0] fifo_id_q  [2];
    logic [WIDTH-1:0]         fifo_res_q [2];
    logic                     wr_ptr_q, wr_ptr_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic [1:0]               cnt_q, cnt_d;

    logic                     full_s;
    logic                     empty_s;
    logic                     pop_s;
    logic                     push_s;
    logic [TRANS_ID_BITS-1:0] push_id_s;
    logic [WIDTH-1:0]         push_res_s;
    logic                     fu_ready_s;
    logic                     div_vld_s;
    logic                     div_out_rdy_s;

    assign full_s  = (cnt_q == 2'd2);
    assign empty_s = (cnt_q == 2'd0);
    assign pop_s   = ~empty_s & bus.wb_ready_i;

    // Control FSM: launch, zero-divisor bypass, result capture and flush handling.
    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        id_err_d      = id_err_q;
        push_s        = 1'b0;
        push_id_s     = '0;
        push_res_s    = '0;
        fu_ready_s    = 1'b0;
        div_vld_s     = 1'b0;
        div_out_rdy_s = 1'b0;
        case (state_q)
            IDLE: begin
                // The divider ignores loads while its own registered flush is active.
                fu_ready_s = div_rdy_q & ~bus.flush_i & ~flush_q & ~full_s;
                if (bus.fu_valid_i && fu_ready_s) begin
                    if (bus.op_b_i != {WIDTH{1'b0}}) begin
                        div_vld_s = 1'b1;
                        id_d      = bus.id_i;
                        state_d   = BUSY;
                    end else begin
                        push_s     = 1'b1;
                        push_id_s  = bus.id_i;
                        push_res_s = bus.opcode_i[1] ? bus.op_a_i : {WIDTH{1'b1}};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                div_out_rdy_s = ~full_s;
                if (bus.div_out_vld_i && div_out_rdy_s) begin
                    state_d = IDLE;
                    if (!bus.flush_i) begin
                        push_s     = 1'b1;
                        push_id_s  = id_q;
                        push_res_s = bus.div_res_i;
                        if (bus.div_id_i != id_q) begin
                            id_err_d = 1'b1;
                        end else begin
                            id_err_d = id_err_q;
                        end
                    end else begin
                        push_s = 1'b0;
                    end
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (bus.flush_i) begin
            state_d = IDLE;
            push_s  = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // FIFO pointer/occupancy next-state; a flush empties it outright.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (bus.flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            wr_ptr_d = wr_ptr_q ^ push_s;
            rd_ptr_d = rd_ptr_q ^ pop_s;
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State, handshake history and FIFO storage.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            div_rdy_q     <= 1'b0;
            flush_q       <= 1'b0;
            id_q          <= '0;
            id_err_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            cnt_q         <= 2'd0;
            fifo_id_q[0]  <= '0;
            fifo_id_q[1]  <= '0;
            fifo_res_q[0] <= '0;
            fifo_res_q[1] <= '0;
        end else begin
            state_q   <= state_d;
            div_rdy_q <= bus.div_rdy_i;
            flush_q   <= bus.flush_i;
            id_q      <= id_d;
            id_err_q  <= id_err_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            if (push_s) begin
                fifo_id_q[wr_ptr_q]  <= push_id_s;
                fifo_res_q[wr_ptr_q] <= push_res_s;
            end else begin
                fifo_id_q[wr_ptr_q]  <= fifo_id_q[wr_ptr_q];
                fifo_res_q[wr_ptr_q] <= fifo_res_q[wr_ptr_q];
            end
        end
    end

    assign bus.fu_ready_o    = fu_ready_s;
    assign bus.div_vld_o     = div_vld_s;
    assign bus.div_id_o      = bus.id_i;
    assign bus.div_op_a_o    = bus.op_a_i;
    assign bus.div_op_b_o    = bus.op_b_i;
    assign bus.div_opcode_o  = bus.opcode_i;
    assign bus.div_flush_o   = bus.flush_i;
    assign bus.div_out_rdy_o = div_out_rdy_s;
    assign bus.wb_valid_o    = ~empty_s;
    assign bus.wb_id_o       = fifo_id_q[rd_ptr_q];
    assign bus.wb_result_o   = fifo_res_q[rd_ptr_q];
    assign bus.id_err_o      = id_err_q;

endmodule

// File: tb/tb_div_dispatch.sv
// Directed bench for div_dispatch: the bench plays issue stage, divider and writeback by hand.
module tb_div_dispatch;
    localparam int W  = 64;
    localparam int IB = 3;
    localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    div_dispatch_if #(.WIDTH(W), .TRANS_ID_BITS(IB)) bus ();

    div_dispatch #(.WIDTH(W), .TRANS_ID_BITS(IB)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        chk_cnt = chk_cnt + 1;
        if (obs !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic req(input logic [IB-1:0] id, input logic [1:0] opc,
                       input logic [W-1:0] a, input logic [W-1:0] b);
        bus.fu_valid_i = 1'b1;
        bus.id_i       = id;
        bus.opcode_i   = opc;
        bus.op_a_i     = a;
        bus.op_b_i     = b;
    endtask

    task automatic res(input logic [IB-1:0] id, input logic [W-1:0] r);
        bus.div_out_vld_i = 1'b1;
        bus.div_id_i      = id;
        bus.div_res_i     = r;
    endtask

    task automatic quiet();
        bus.fu_valid_i    = 1'b0;
        bus.div_out_vld_i = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni            = 1'b0;
        bus.flush_i       = 1'b0;
        bus.fu_valid_i    = 1'b0;
        bus.id_i          = '0;
        bus.op_a_i        = '0;
        bus.op_b_i        = '0;
        bus.opcode_i      = 2'd0;
        bus.div_rdy_i     = 1'b1;
        bus.div_out_vld_i = 1'b0;
        bus.div_id_i      = '0;
        bus.div_res_i     = '0;
        bus.wb_ready_i    = 1'b1;
        step();
        step();

        // First cycle after reset: div_rdy_q still 0, so nothing may launch.
        rst_ni = 1'b1;
        req(3'd2, 2'd0, 64'd100, 64'd7);
        settle();
        check_eq("rst_fu_ready", bus.fu_ready_o, 64'd0);
        check_eq("rst_div_vld", bus.div_vld_o, 64'd0);
        check_eq("rst_wb_valid", bus.wb_valid_o, 64'd0);
        check_eq("rst_out_rdy", bus.div_out_rdy_o, 64'd0);
        check_eq("rst_id_err", bus.id_err_o, 64'd0);
        step();

        // udiv 100/7 id 2 -> divider returns 14
        check_eq("udiv_launch", bus.div_vld_o, 64'd1);
        check_eq("udiv_div_id", bus.div_id_o, 64'd2);
        check_eq("udiv_op_a", bus.div_op_a_o, 64'd100);
        check_eq("udiv_op_b", bus.div_op_b_o, 64'd7);
        check_eq("udiv_opcode", bus.div_opcode_o, 64'd0);
        step();
        quiet();
        settle();
        check_eq("busy_no_vld", bus.div_vld_o, 64'd0);
        check_eq("busy_fu_ready", bus.fu_ready_o, 64'd0);
        check_eq("busy_out_rdy", bus.div_out_rdy_o, 64'd1);
        res(3'd2, 64'd14);
        settle();
        check_eq("busy_no_vld2", bus.div_vld_o, 64'd0);
        step();
        quiet();
        settle();
        check_eq("udiv_wb_valid", bus.wb_valid_o, 64'd1);
        check_eq("udiv_wb_id", bus.wb_id_o, 64'd2);
        check_eq("udiv_wb_res", bus.wb_result_o, 64'd14);
        check_eq("udiv_id_err", bus.id_err_o, 64'd0);
        step();
        check_eq("udiv_popped", bus.wb_valid_o, 64'd0);

        // rem -7 % 2, divider returns all ones
        req(3'd1, 2'd3, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        settle();
        check_eq("rem_launch", bus.div_vld_o, 64'd1);
        check_eq("rem_opcode", bus.div_opcode_o, 64'd3);
        step();
        quiet();
        res(3'd1, ONES);
        step();
        quiet();
        settle();
        check_eq("rem_wb_id", bus.wb_id_o, 64'd1);
        check_eq("rem_wb_res", bus.wb_result_o, ONES);
        step();

        // div 5/0 bypass, then urem 5/0 pushed while the first is popped
        req(3'd3, 2'd1, 64'd5, 64'd0);
        settle();
        check_eq("div0_fu_ready", bus.fu_ready_o, 64'd1);
        check_eq("div0_no_vld", bus.div_vld_o, 64'd0);
        step();
        quiet();
        settle();
        check_eq("div0_wb_valid", bus.wb_valid_o, 64'd1);
        check_eq("div0_wb_id", bus.wb_id_o, 64'd3);
        check_eq("div0_wb_res", bus.wb_result_o, ONES);
        req(3'd4, 2'd2, 64'd5, 64'd0);
        settle();
        check_eq("urem0_fu_ready", bus.fu_ready_o, 64'd1);
        check_eq("urem0_no_vld", bus.div_vld_o, 64'd0);
        step();
        quiet();
        settle();
        check_eq("urem0_wb_id", bus.wb_id_o, 64'd4);
        check_eq("urem0_wb_res", bus.wb_result_o, 64'd5);
        step();
        check_eq("urem0_popped", bus.wb_valid_o, 64'd0);

        // Flush during BUSY with a queued entry and a racing result and request
        bus.wb_ready_i = 1'b0;
        req(3'd6, 2'd1, 64'd9, 64'd0);
        step();
        req(3'd5, 2'd0, 64'd20, 64'd3);
        settle();
        check_eq("fl_launch", bus.div_vld_o, 64'd1);
        step();
        check_eq("fl_queued", bus.wb_valid_o, 64'd1);
        check_eq("fl_flush_low", bus.div_flush_o, 64'd0);
        bus.flush_i = 1'b1;
        res(3'd5, 64'd6);
        req(3'd7, 2'd0, 64'd20, 64'd3);
        settle();
        check_eq("fl_div_flush", bus.div_flush_o, 64'd1);
        check_eq("fl_fu_ready", bus.fu_ready_o, 64'd0);
        check_eq("fl_no_vld", bus.div_vld_o, 64'd0);
        step();
        bus.flush_i       = 1'b0;
        bus.div_out_vld_i = 1'b0;
        settle();
        check_eq("fl_fifo_empty", bus.wb_valid_o, 64'd0);
        check_eq("fl_q_fu_ready", bus.fu_ready_o, 64'd0);
        check_eq("fl_q_no_vld", bus.div_vld_o, 64'd0);
        step();
        check_eq("fl_relaunch_rdy", bus.fu_ready_o, 64'd1);
        check_eq("fl_relaunch", bus.div_vld_o, 64'd1);
        check_eq("fl_relaunch_id", bus.div_id_o, 64'd7);
        step();
        quiet();
        res(3'd7, 64'd6);
        step();
        quiet();
        settle();
        check_eq("fl_wb_id", bus.wb_id_o, 64'd7);
        check_eq("fl_wb_res", bus.wb_result_o, 64'd6);
        check_eq("fl_id_err", bus.id_err_o, 64'd0);
        bus.wb_ready_i = 1'b1;
        step();
        check_eq("fl_popped", bus.wb_valid_o, 64'd0);

        // Backpressure: two results fill the FIFO, the third request stalls
        bus.wb_ready_i = 1'b0;
        req(3'd1, 2'd0, 64'd50, 64'd5);
        step();
        quiet();
        res(3'd1, 64'd10);
        step();
        quiet();
        req(3'd2, 2'd0, 64'd60, 64'd5);
        settle();
        check_eq("bp_b_ready", bus.fu_ready_o, 64'd1);
        check_eq("bp_b_launch", bus.div_vld_o, 64'd1);
        step();
        quiet();
        res(3'd2, 64'd12);
        step();
        quiet();
        req(3'd3, 2'd0, 64'd70, 64'd5);
        settle();
        check_eq("bp_full_ready", bus.fu_ready_o, 64'd0);
        check_eq("bp_full_no_vld", bus.div_vld_o, 64'd0);
        check_eq("bp_full_out_rdy", bus.div_out_rdy_o, 64'd0);
        check_eq("bp_head_id", bus.wb_id_o, 64'd1);
        check_eq("bp_head_res", bus.wb_result_o, 64'd10);
        step();
        check_eq("bp_still_stall", bus.div_vld_o, 64'd0);
        bus.wb_ready_i = 1'b1;
        settle();
        check_eq("bp_pop_pending", bus.div_vld_o, 64'd0);
        step();
        check_eq("bp_second_id", bus.wb_id_o, 64'd2);
        check_eq("bp_second_res", bus.wb_result_o, 64'd12);
        check_eq("bp_c_launch", bus.div_vld_o, 64'd1);
        check_eq("bp_c_id", bus.div_id_o, 64'd3);
        step();
        quiet();
        settle();
        check_eq("bp_drained", bus.wb_valid_o, 64'd0);
        res(3'd3, 64'd14);
        step();
        quiet();
        settle();
        check_eq("bp_third_id", bus.wb_id_o, 64'd3);
        check_eq("bp_third_res", bus.wb_result_o, 64'd14);
        step();

        // Result id mismatch -> sticky error
        req(3'd2, 2'd0, 64'd12, 64'd4);
        step();
        quiet();
        res(3'd5, 64'd3);
        settle();
        check_eq("err_before", bus.id_err_o, 64'd0);
        step();
        quiet();
        settle();
        check_eq("err_set", bus.id_err_o, 64'd1);
        check_eq("err_wb_id", bus.wb_id_o, 64'd2);
        req(3'd0, 2'd1, 64'd1, 64'd0);
        step();
        quiet();
        step();
        check_eq("err_sticky", bus.id_err_o, 64'd1);

        // Reset mid-divide, then a late divider result must be ignored
        req(3'd4, 2'd0, 64'd8, 64'd2);
        settle();
        check_eq("mr_launch", bus.div_vld_o, 64'd1);
        step();
        quiet();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        settle();
        check_eq("mr_id_err", bus.id_err_o, 64'd0);
        check_eq("mr_fu_ready", bus.fu_ready_o, 64'd0);
        res(3'd4, 64'd4);
        settle();
        check_eq("mr_out_rdy", bus.div_out_rdy_o, 64'd0);
        step();
        check_eq("mr_wb_valid", bus.wb_valid_o, 64'd0);
        check_eq("mr_out_rdy2", bus.div_out_rdy_o, 64'd0);
        check_eq("mr_idle_ready", bus.fu_ready_o, 64'd1);
        quiet();
        step();
        check_eq("mr_wb_valid2", bus.wb_valid_o, 64'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
